pim_dma_ctrl: RTL and testbench
===============================

Name: pim_dma_ctrl

Overview:
- Bus-master DMA engine that drives the DMA request/grant port and both DMA channels of the system bus.
- Copies a block of 32-bit words between the PIM buffer SRAM (channel 0, region 0x2xxx_xxxx) and the Hybrid-PIM macro (channel 1, region 0x4xxx_xxxx), in either direction.
- Read and write run pipelined at up to 1 word/cycle. The engine tolerates grant loss at any cycle, since SPI and RV DMEM have higher priority.

Parameters:
LEN_W, 16, width of word-count field (max transfer 2^LEN_W-1 words)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_start  in  1  1-cycle start pulse, sampled only in IDLE
i_dir  in  1  0: buffer->PIM (ch0 read, ch1 write); 1: PIM->buffer (ch1 read, ch0 write)
i_src_addr  in  32  source byte address
i_dst_addr  in  32  destination byte address
i_len  in  LEN_W  number of words
i_abort  in  1  abort current transfer
o_busy  out  1  transfer in progress
o_done  out  1  1-cycle pulse on completion
o_err  out  1  sticky config error, cleared by next accepted i_start
o_req_dma  out  1  bus request
i_gnt_dma  in  1  bus grant
o_dma_addr_0 / o_dma_write_0 / o_dma_read_0  out  32/1/1  channel 0 (buffer) address and strobes
o_dma_size_0  out  4  channel 0 byte enable
o_dma_din_0  out  32  channel 0 write data
i_dma_dout_0  in  32  channel 0 read data
o_dma_addr_1 / o_dma_write_1 / o_dma_read_1 / o_dma_size_1 / o_dma_din_1  out  32/1/1/4/32  channel 1 (PIM) equivalents
i_dma_dout_1  in  32  channel 1 read data

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values: all outputs 0, FSM in IDLE, all counters and flags 0.
- FSM states: IDLE, CHECK, RUN, DONE.
- IDLE -> CHECK on i_start. In that cycle: latch src, dst, len and dir, and clear o_err.
- CHECK (1 cycle) sets o_err and returns to IDLE, with no bus activity, if any of the following holds:
  - src[1:0] or dst[1:0] is nonzero;
  - the source region (addr[31:28]) is not 0x2 when dir=0, or not 0x4 when dir=1;
  - the destination region is not the opposite one (0x4 when dir=0, 0x2 when dir=1);
  - addr[27:0] + 4*len > 2^28 for src or for dst (the block would cross its region).
- CHECK -> DONE directly if len==0. Otherwise CHECK -> RUN.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- o_busy=1 in CHECK and RUN.
- Bus timing:
  - A beat fires when its read or write strobe is high at a rising edge with i_gnt_dma=1.
  - Read data is valid on the read channel's dout in the cycle after a fired read, regardless of the grant in that cycle.
  - o_size is always 4'b1111.
  - Addresses and strobes of an idle channel are 0.
- Counters:
  - rd_cnt counts fired reads; read address = src + 4*rd_cnt.
  - wr_cnt counts fired writes; write address = dst + 4*wr_cnt.
- Pipeline state:
  - rd_inflight: a read fired last cycle.
  - hold_vld / hold_data: a one-entry holding register.
  - Invariant: occ = rd_inflight + hold_vld <= 1.
- Write path in RUN:
  - Write strobe = (occ==1).
  - Write data = i_dout of the read channel if rd_inflight, else hold_data.
  - If rd_inflight is set and the write does not fire, capture i_dout into hold_data and set hold_vld.
  - hold_vld clears when a write sourced from hold fires.
- Read path in RUN:
  - Read strobe = (rd_cnt < len).
  - Because read and write share the grant, occ never exceeds 1.
- o_req_dma = read strobe OR write strobe.
- RUN -> DONE when the write with wr_cnt==len-1 fires.
- Grant low: no counters advance and strobes and addresses are held stable. In-flight data is preserved in hold.
- i_abort (any state other than IDLE): next state is IDLE and all strobes drop that cycle. Pending data is discarded, o_done does not pulse, and o_err is unchanged.
- i_start while busy: ignored.
- Async reset mid-transfer: immediate return to reset values. No resume.

Test Plan:
- dir=0, src=0x2000_0000, dst=0x4000_0010, len=4, grant held high -> reads to 0x2000_0000..0C on cycles R..R+3; writes to 0x4000_0010..1C on R+1..R+4 with matching data; o_done exactly 1 cycle at R+5; o_req_dma high for 5 cycles.
- dir=1, src=0x4000_0000, dst=0x2000_0100, len=3 -> ch1 reads, ch0 writes; buffer words 0x100..0x108 equal the PIM words.
- len=8, grant dropped for 3 cycles right after the 2nd read fires -> strobes frozen; the inflight word is held and written after grant returns; all 8 words are correct; no duplicate or skipped address.
- Config errors: src=0x2000_0002, or dir=0 with dst=0x8000_0000, or src=0x2FFF_FFF8 with len=4 -> o_err=1 two cycles after start; no strobes; o_done stays 0.
- len=0 -> o_done pulses; no o_req_dma. Then i_abort at the 3rd beat of len=16 -> strobes 0 next cycle; IDLE; no o_done; a new start is accepted.
- i_rst_n asserted mid-RUN -> all outputs 0 asynchronously; after release, i_start with len=2 completes normally.

Source files
------------

// File: rtl/pim_dma_ctrl.sv
// Bus-master DMA engine: copies 32-bit words between PIM buffer SRAM
// (channel 0) and the Hybrid-PIM macro (channel 1), pipelined 1 word/cycle.
module pim_dma_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic [31:0]      i_src_addr,
  input  logic [31:0]      i_dst_addr,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic             o_req_dma,
  input  logic             i_gnt_dma,
  output logic [31:0]      o_dma_addr_0,
  output logic             o_dma_write_0,
  output logic             o_dma_read_0,
  output logic [3:0]       o_dma_size_0,
  output logic [31:0]      o_dma_din_0,
  input  logic [31:0]      i_dma_dout_0,
  output logic [31:0]      o_dma_addr_1,
  output logic             o_dma_write_1,
  output logic             o_dma_read_1,
  output logic [3:0]       o_dma_size_1,
  output logic [31:0]      o_dma_din_1,
  input  logic [31:0]      i_dma_dout_1
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             rd_inf_q, rd_inf_d;
  logic             hold_vld_q, hold_vld_d;
  logic [31:0]      hold_data_q, hold_data_d;

  logic             run;
  logic             occ;
  logic             rd_stb;
  logic             wr_stb;
  logic             rd_fire;
  logic             wr_fire;
  logic             last_wr;
  logic [31:0]      rd_data;
  logic [31:0]      wr_data;
  logic [31:0]      rd_addr;
  logic [31:0]      wr_addr;
  logic [29:0]      src_end;
  logic [29:0]      dst_end;
  logic [3:0]       src_rgn;
  logic [3:0]       dst_rgn;
  logic             cfg_bad;

  // Abort kills all strobes in the cycle it is seen
  assign run     = (state_q == S_RUN) && !i_abort;
  assign occ     = rd_inf_q | hold_vld_q;
  assign rd_stb  = run && (rd_cnt_q < len_q);
  assign wr_stb  = run && occ;
  assign rd_fire = rd_stb & i_gnt_dma;
  assign wr_fire = wr_stb & i_gnt_dma;
  assign last_wr = wr_fire &&
                   (wr_cnt_q == len_q - LEN_W'(1));

  assign rd_data = dir_q ? i_dma_dout_1
                         : i_dma_dout_0;
  assign wr_data = rd_inf_q ? rd_data
                            : hold_data_q;
  assign rd_addr = src_q + 32'({rd_cnt_q, 2'b00});
  assign wr_addr = dst_q + 32'({wr_cnt_q, 2'b00});

  assign src_end = {2'b00, src_q[27:0]} +
                   30'({len_q, 2'b00});
  assign dst_end = {2'b00, dst_q[27:0]} +
                   30'({len_q, 2'b00});
  assign src_rgn = dir_q ? 4'h4 : 4'h2;
  assign dst_rgn = dir_q ? 4'h2 : 4'h4;

  assign cfg_bad = (|src_q[1:0]) ||
                   (|dst_q[1:0]) ||
                   (src_q[31:28] != src_rgn) ||
                   (dst_q[31:28] != dst_rgn) ||
                   (src_end > 30'h1000_0000) ||
                   (dst_end > 30'h1000_0000);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (cfg_bad)
          state_d = S_IDLE;
        else if (len_q == '0)
          state_d = S_DONE;
        else
          state_d = S_RUN;
      end
      S_RUN: begin
        if (last_wr) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (i_abort && state_q != S_IDLE)
      state_d = S_IDLE;
  end

  always_comb begin
    o_busy        = (state_q == S_CHECK) ||
                    (state_q == S_RUN);
    o_done        = (state_q == S_DONE) && !i_abort;
    o_err         = err_q;
    o_req_dma     = rd_stb | wr_stb;
    o_dma_size_0  = 4'b1111;
    o_dma_size_1  = 4'b1111;
    o_dma_read_0  = !dir_q & rd_stb;
    o_dma_write_0 = dir_q & wr_stb;
    o_dma_read_1  = dir_q & rd_stb;
    o_dma_write_1 = !dir_q & wr_stb;
    o_dma_addr_0  = '0;
    o_dma_addr_1  = '0;
    o_dma_din_0   = '0;
    o_dma_din_1   = '0;
    if (o_dma_read_0)  o_dma_addr_0 = rd_addr;
    if (o_dma_write_0) begin
      o_dma_addr_0 = wr_addr;
      o_dma_din_0  = wr_data;
    end
    if (o_dma_read_1)  o_dma_addr_1 = rd_addr;
    if (o_dma_write_1) begin
      o_dma_addr_1 = wr_addr;
      o_dma_din_1  = wr_data;
    end
  end

  always_comb begin
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    dir_d       = dir_q;
    err_d       = err_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    rd_inf_d    = rd_inf_q;
    hold_vld_d  = hold_vld_q;
    hold_data_d = hold_data_q;
    if (state_q == S_IDLE && i_start) begin
      src_d = i_src_addr;
      dst_d = i_dst_addr;
      len_d = i_len;
      dir_d = i_dir;
      err_d = 1'b0;
    end
    if (state_q == S_CHECK && !i_abort && cfg_bad)
      err_d = 1'b1;
    if (!run) begin
      rd_cnt_d   = '0;
      wr_cnt_d   = '0;
      rd_inf_d   = 1'b0;
      hold_vld_d = 1'b0;
    end else begin
      rd_cnt_d = rd_cnt_q + LEN_W'(rd_fire);
      wr_cnt_d = wr_cnt_q + LEN_W'(wr_fire);
      rd_inf_d = rd_fire;
      // Park the returning word when the write side is stalled
      if (rd_inf_q && !wr_fire) begin
        hold_vld_d  = 1'b1;
        hold_data_d = rd_data;
      end else if (wr_fire) begin
        hold_vld_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      rd_inf_q    <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_data_q <= '0;
    end else begin
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_inf_q    <= rd_inf_d;
      hold_vld_q  <= hold_vld_d;
      hold_data_q <= hold_data_d;
    end
  end

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// Directed bench for pim_dma_ctrl with buffer/PIM memory models
// and bounded waits on completion.
module tb_pim_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic        abort = 1'b0;
  logic        busy, done, err, req;
  logic        gnt = 1'b1;
  logic [31:0] a0, a1, din0, din1;
  logic        wr0, rd0, wr1, rd1;
  logic [3:0]  sz0, sz1;
  logic [31:0] dout0 = '0;
  logic [31:0] dout1 = '0;

  logic [31:0] m0 [1024];
  logic [31:0] m1 [1024];
  bit          w0 [1024];
  bit          w1 [1024];

  int total = 0;
  int bad = 0;
  int rdf = 0;
  int wrf = 0;
  int donec = 0;
  int s_rd, s_wr, s_dn;

  always #5 clk = ~clk;

  pim_dma_ctrl #(.LEN_W(16)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_dir        (dir),
    .i_src_addr   (src),
    .i_dst_addr   (dst),
    .i_len        (len),
    .i_abort      (abort),
    .o_busy       (busy),
    .o_done       (done),
    .o_err        (err),
    .o_req_dma    (req),
    .i_gnt_dma    (gnt),
    .o_dma_addr_0 (a0),
    .o_dma_write_0(wr0),
    .o_dma_read_0 (rd0),
    .o_dma_size_0 (sz0),
    .o_dma_din_0  (din0),
    .i_dma_dout_0 (dout0),
    .o_dma_addr_1 (a1),
    .o_dma_write_1(wr1),
    .o_dma_read_1 (rd1),
    .o_dma_size_1 (sz1),
    .o_dma_din_1  (din1),
    .i_dma_dout_1 (dout1)
  );

  // Unwritten buffer words read as A000_0000+idx, PIM words as B000_0000+idx
  always @(posedge clk) begin
    if (done) donec <= donec + 1;
    if (gnt) begin
      if (rd0) begin
        dout0 <= w0[a0[11:2]] ? m0[a0[11:2]]
                              : 32'hA000_0000 + 32'(a0[11:2]);
        rdf <= rdf + 1;
      end
      if (rd1) begin
        dout1 <= w1[a1[11:2]] ? m1[a1[11:2]]
                              : 32'hB000_0000 + 32'(a1[11:2]);
        rdf <= rdf + 1;
      end
      if (wr0) begin
        m0[a0[11:2]] <= din0;
        w0[a0[11:2]] <= 1'b1;
        wrf <= wrf + 1;
      end
      if (wr1) begin
        m1[a1[11:2]] <= din1;
        w1[a1[11:2]] <= 1'b1;
        wrf <= wrf + 1;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic d, input logic [31:0] s,
                    input logic [31:0] t, input logic [15:0] l);
    dir   = d;
    src   = s;
    dst   = t;
    len   = l;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    chk(tag, 32'(done), 32'd1);
    step();
  endtask

  initial begin
    step();
    step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_req", 32'(req), 0);
    chk("rst_strb", {28'd0, rd0, wr0, rd1, wr1}, 0);
    chk("rst_addr", a0 | a1, 0);
    #2 rst_n = 1'b1;
    step();

    // T1: buffer -> PIM, len 4, timing check
    s_dn = donec;
    go(1'b0, 32'h2000_0000, 32'h4000_0010, 16'd4);
    chk("t1_chk_busy", 32'(busy), 1);
    chk("t1_chk_req", 32'(req), 0);
    step();
    chk("t1_r0_rd", 32'(rd0), 1);
    chk("t1_r0_addr", a0, 32'h2000_0000);
    chk("t1_r0_wr", 32'(wr1), 0);
    chk("t1_r0_size", 32'(sz0), 32'hF);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t1_rd", 32'(rd0), (k < 4) ? 1 : 0);
      if (k < 4)
        chk("t1_rd_addr", a0, 32'h2000_0000 + 32'(4 * k));
      chk("t1_wr", 32'(wr1), 1);
      chk("t1_wr_addr", a1, 32'h4000_0010 + 32'(4 * (k - 1)));
      chk("t1_wr_data", din1, 32'hA000_0000 + 32'(k - 1));
      chk("t1_req", 32'(req), 1);
      chk("t1_nodone", 32'(done), 0);
    end
    step();
    chk("t1_done", 32'(done), 1);
    chk("t1_req_off", 32'(req), 0);
    chk("t1_busy_off", 32'(busy), 0);
    step();
    chk("t1_done_1cyc", 32'(done), 0);
    chk("t1_done_cnt", 32'(donec - s_dn), 1);
    for (int i = 0; i < 4; i++)
      chk("t1_mem", m1[4 + i], 32'hA000_0000 + 32'(i));

    // T2: PIM -> buffer, len 3
    s_rd = rdf;
    s_wr = wrf;
    go(1'b1, 32'h4000_0000, 32'h2000_0100, 16'd3);
    wait_done("t2_done");
    chk("t2_rdcnt", 32'(rdf - s_rd), 3);
    chk("t2_wrcnt", 32'(wrf - s_wr), 3);
    for (int i = 0; i < 3; i++)
      chk("t2_mem", m0[64 + i], 32'hB000_0000 + 32'(i));

    // T3: len 8 with a 3-cycle grant loss after the 2nd read
    s_rd = rdf;
    s_wr = wrf;
    go(1'b0, 32'h2000_0020, 32'h4000_0040, 16'd8);
    step();
    step();
    step();
    gnt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t3_frz_rd", 32'(rd0), 1);
      chk("t3_frz_raddr", a0, 32'h2000_0028);
      chk("t3_frz_wr", 32'(wr1), 1);
      chk("t3_frz_waddr", a1, 32'h4000_0044);
      chk("t3_frz_data", din1, 32'hA000_0009);
      step();
    end
    gnt = 1'b1;
    wait_done("t3_done");
    chk("t3_rdcnt", 32'(rdf - s_rd), 8);
    chk("t3_wrcnt", 32'(wrf - s_wr), 8);
    for (int i = 0; i < 8; i++)
      chk("t3_mem", m1[16 + i], 32'hA000_0008 + 32'(i));

    // T4: configuration errors
    s_rd = rdf;
    s_wr = wrf;
    s_dn = donec;
    go(1'b0, 32'h2000_0002, 32'h4000_0000, 16'd4);
    chk("t4a_req", 32'(req), 0);
    step();
    chk("t4a_err", 32'(err), 1);
    chk("t4a_busy", 32'(busy), 0);
    go(1'b0, 32'h2000_0000, 32'h8000_0000, 16'd4);
    chk("t4b_err_clr", 32'(err), 0);
    chk("t4b_req", 32'(req), 0);
    step();
    chk("t4b_err", 32'(err), 1);
    go(1'b0, 32'h2FFF_FFF8, 32'h4000_0000, 16'd4);
    step();
    chk("t4c_err", 32'(err), 1);
    chk("t4c_req", 32'(req), 0);
    step();
    chk("t4_nobus", 32'((rdf - s_rd) + (wrf - s_wr)), 0);
    chk("t4_nodone", 32'(donec - s_dn), 0);

    // T5: zero length, then abort
    go(1'b0, 32'h2000_0000, 32'h4000_0000, 16'd0);
    chk("t5_err_clr", 32'(err), 0);
    chk("t5_chk_req", 32'(req), 0);
    step();
    chk("t5_len0_done", 32'(done), 1);
    chk("t5_len0_req", 32'(req), 0);
    step();
    s_dn = donec;
    go(1'b0, 32'h2000_0000, 32'h4000_0400, 16'd16);
    step();
    step();
    step();
    chk("t5_beat3_rd", 32'(rd0), 1);
    abort = 1'b1;
    #1;
    chk("t5_abort_strb", {28'd0, rd0, wr0, rd1, wr1}, 0);
    chk("t5_abort_req", 32'(req), 0);
    step();
    abort = 1'b0;
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_req", 32'(req), 0);
    step();
    step();
    chk("t5_no_done", 32'(donec - s_dn), 0);
    chk("t5_err_keep", 32'(err), 0);
    go(1'b0, 32'h2000_0000, 32'h4000_0100, 16'd2);
    wait_done("t5_restart");
    chk("t5_mem0", m1[64], 32'hA000_0000);
    chk("t5_mem1", m1[65], 32'hA000_0001);

    // T6: asynchronous reset mid-run
    go(1'b0, 32'h2000_0000, 32'h4000_0200, 16'd4);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_req", 32'(req), 0);
    chk("t6_strb", {28'd0, rd0, wr0, rd1, wr1}, 0);
    chk("t6_addr", a0 | a1, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_idle", 32'(busy), 0);
    go(1'b0, 32'h2000_0010, 32'h4000_0300, 16'd2);
    wait_done("t6_done");
    chk("t6_mem0", m1[192], 32'hA000_0004);
    chk("t6_mem1", m1[193], 32'hA000_0005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
